fm_add_rd_sched: RTL and testbench



---
 rtl/fm_add_rd_sched.sv | 143 ++++++++++++++
 tb/tb_fm_add_rd_sched.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fm_add_rd_sched.sv
// rtl/fm_add_rd_sched.sv - DDR read scheduler: issues beat reads, tracks returns, writes assembled words to BRAM
module fm_add_rd_sched #(
   parameter int SEQ_CNT         = 5,
   parameter int APP_DATA_WIDTH  = 64,
   parameter int APP_ADDR_WIDTH  = 29,
   parameter int ADDR_STEP       = 8,
   parameter int BRAM_ADDR_WIDTH = 10,
   parameter int MAX_OUT         = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic [APP_ADDR_WIDTH-1:0]  base_addr,
   input  logic [BRAM_ADDR_WIDTH:0]   word_cnt,
   output logic                       busy,
   output logic                       done,
   output logic                       app_en,
   output logic [2:0]                 app_cmd,
   output logic [APP_ADDR_WIDTH-1:0]  app_addr,
   input  logic                       app_rdy,
   input  logic [APP_DATA_WIDTH-1:0]  app_rd_data,
   input  logic                       app_rd_data_valid,
   output logic                       s2p_clr,
   output logic                       seq_en,
   output logic [APP_DATA_WIDTH-1:0]  seq,
   input  logic                       par_valid,
   output logic                       bram_we,
   output logic [BRAM_ADDR_WIDTH-1:0] bram_addr
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_FIN   = 2'd3;

   // Beat counters must hold the largest word_cnt times SEQ_CNT.
   localparam int TOT_W = BRAM_ADDR_WIDTH + 1 + $clog2(SEQ_CNT + 1);
   localparam int OUT_W = $clog2(MAX_OUT) + 1;
   localparam logic [TOT_W-1:0] SEQ_CNT_W = TOT_W'(SEQ_CNT);
   localparam logic [OUT_W-1:0] MAX_OUT_W = OUT_W'(MAX_OUT);

   logic [1:0]                 state_q, state_d;
   logic [APP_ADDR_WIDTH-1:0]  addr_q, addr_d;
   logic [TOT_W-1:0]           total_q, total_d;
   logic [TOT_W-1:0]           issued_q, issued_d;
   logic [OUT_W-1:0]           outst_q, outst_d;
   logic [BRAM_ADDR_WIDTH:0]   words_q, words_d;
   logic [BRAM_ADDR_WIDTH:0]   wr_cnt_q, wr_cnt_d;
   logic [BRAM_ADDR_WIDTH-1:0] bram_addr_q, bram_addr_d;
   logic                       s2p_clr_q, s2p_clr_d;
   logic                       accept;
   logic [BRAM_ADDR_WIDTH:0]   written_nxt;

   always_comb begin
      busy        = (state_q == S_ISSUE) || (state_q == S_DRAIN);
      done        = (state_q == S_FIN);
      app_en      = (state_q == S_ISSUE) && (issued_q < total_q) && (outst_q < MAX_OUT_W);
      app_cmd     = 3'b001;
      app_addr    = addr_q;
      accept      = app_en && app_rdy;
      seq_en      = busy && app_rd_data_valid;
      seq         = app_rd_data;
      bram_we     = busy && par_valid;
      bram_addr   = bram_addr_q;
      s2p_clr     = s2p_clr_q;
      written_nxt = wr_cnt_q + (bram_we ? {{BRAM_ADDR_WIDTH{1'b0}}, 1'b1} : '0);
   end

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      total_d     = total_q;
      issued_d    = issued_q;
      outst_d     = outst_q;
      words_d     = words_q;
      wr_cnt_d    = wr_cnt_q;
      bram_addr_d = bram_addr_q;
      s2p_clr_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               s2p_clr_d   = 1'b1;
               addr_d      = base_addr;
               words_d     = word_cnt;
               total_d     = TOT_W'(word_cnt) * SEQ_CNT_W;
               issued_d    = '0;
               outst_d     = '0;
               wr_cnt_d    = '0;
               bram_addr_d = '0;
               state_d     = (word_cnt != '0) ? S_ISSUE : S_FIN;
            end
         end
         S_ISSUE, S_DRAIN: begin
            if (accept) begin
               issued_d = issued_q + TOT_W'(1);
               addr_d   = addr_q + APP_ADDR_WIDTH'(ADDR_STEP);
            end
            // A return in the same cycle as an accept leaves the count unchanged.
            if (accept && !app_rd_data_valid)
               outst_d = outst_q + OUT_W'(1);
            else if (!accept && app_rd_data_valid && (outst_q != '0))
               outst_d = outst_q - OUT_W'(1);
            if (bram_we) begin
               bram_addr_d = bram_addr_q + BRAM_ADDR_WIDTH'(1);
               wr_cnt_d    = written_nxt;
            end
            if (state_q == S_ISSUE) begin
               if (accept && (issued_q + TOT_W'(1) == total_q))
                  state_d = S_DRAIN;
            end else if (written_nxt == words_q) begin
               state_d = S_FIN;
            end
         end
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         total_q     <= '0;
         issued_q    <= '0;
         outst_q     <= '0;
         words_q     <= '0;
         wr_cnt_q    <= '0;
         bram_addr_q <= '0;
         s2p_clr_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         total_q     <= total_d;
         issued_q    <= issued_d;
         outst_q     <= outst_d;
         words_q     <= words_d;
         wr_cnt_q    <= wr_cnt_d;
         bram_addr_q <= bram_addr_d;
         s2p_clr_q   <= s2p_clr_d;
      end
   end

endmodule

// File: tb/tb_fm_add_rd_sched.sv
// tb/tb_fm_add_rd_sched.sv - scoreboard bench with DDR latency model and serial-to-parallel model
module tb_fm_add_rd_sched;

   localparam int SEQ_CNT = 5;
   localparam int MAX_OUT = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [28:0] base_addr;
   logic [10:0] word_cnt;
   logic        busy, done, app_en, app_rdy, app_rd_data_valid;
   logic [2:0]  app_cmd;
   logic [28:0] app_addr;
   logic [63:0] app_rd_data, seq;
   logic        s2p_clr, seq_en, par_valid, bram_we;
   logic [9:0]  bram_addr;

   fm_add_rd_sched dut (
      .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .word_cnt(word_cnt),
      .busy(busy), .done(done), .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr),
      .app_rdy(app_rdy), .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
      .s2p_clr(s2p_clr), .seq_en(seq_en), .seq(seq), .par_valid(par_valid),
      .bram_we(bram_we), .bram_addr(bram_addr)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   logic [28:0] exp_addr_q[$];
   logic [9:0]  exp_bram_q[$];
   logic [63:0] seq_q[$];
   int          ddr_due[$];
   int  cyc = 0, lat = 4;
   bit  rdy_rand = 0, junk_valid = 0;
   int  acc_cnt, wr_cnt, done_cnt, s2p_cnt, tb_outst, max_outst, last_we_cyc, done_cyc;
   int  beats = 0;
   bit  pend = 0, prev_stall = 0;
   logic [28:0] prev_addr;

   // DDR and serial-to-parallel models: drive at negedge, sample 1ns later.
   always begin
      @(negedge clk);
      cyc++;
      app_rdy   = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      par_valid = pend;
      pend      = 0;
      if (ddr_due.size() > 0 && ddr_due[0] <= cyc) begin
         void'(ddr_due.pop_front());
         app_rd_data_valid = 1'b1;
         app_rd_data       = {$urandom, $urandom};
         seq_q.push_back(app_rd_data);
         tb_outst--;
      end else begin
         app_rd_data_valid = junk_valid;
         app_rd_data       = 64'hdead_beef_0bad_f00d;
      end
      #1;
      if (!rst_n) begin
         ddr_due.delete();
         seq_q.delete();
         tb_outst   = 0;
         beats      = 0;
         pend       = 0;
         prev_stall = 0;
      end else begin
         if (prev_stall) chk("stall_hold", {34'd0, app_en, app_addr}, {34'd0, 1'b1, prev_addr});
         prev_stall = app_en && !app_rdy;
         prev_addr  = app_addr;
         if (app_en) chk("outst_lim", 64'(tb_outst < MAX_OUT), 64'd1);
         if (app_en && app_rdy) begin
            acc_cnt++;
            tb_outst++;
            chk("app_cmd", 64'(app_cmd), 64'd1);
            if (exp_addr_q.size() > 0) chk("app_addr", 64'(app_addr), 64'(exp_addr_q.pop_front()));
            else chk("extra_accept", 64'd1, 64'd0);
            ddr_due.push_back(cyc + lat);
         end
         if (tb_outst > max_outst) max_outst = tb_outst;
         if (junk_valid) begin
            chk("idle_seq_en", 64'(seq_en), 64'd0);
         end else if (app_rd_data_valid) begin
            chk("seq_en", 64'(seq_en), 64'd1);
            chk("seq", seq, seq_q.pop_front());
            beats++;
            if (beats == SEQ_CNT) begin
               pend  = 1;
               beats = 0;
            end
         end
         if (bram_we) begin
            wr_cnt++;
            last_we_cyc = cyc;
            if (exp_bram_q.size() > 0) chk("bram_addr", 64'(bram_addr), 64'(exp_bram_q.pop_front()));
            else chk("extra_write", 64'd1, 64'd0);
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (s2p_clr) begin
            s2p_cnt++;
            beats = 0;
         end
      end
   end

   task automatic start_job(input logic [28:0] base, input logic [10:0] cnt, input bit expect_accept);
      @(negedge clk);
      #2;
      rst_n     = 1'b1;
      start     = 1'b1;
      base_addr = base;
      word_cnt  = cnt;
      if (expect_accept) begin
         acc_cnt = 0; wr_cnt = 0; done_cnt = 0; s2p_cnt = 0; max_outst = 0;
         for (int i = 0; i < cnt * SEQ_CNT; i++) exp_addr_q.push_back(base + 29'(i * 8));
         for (int i = 0; i < cnt; i++) exp_bram_q.push_back(10'(i));
      end
      @(negedge clk);
      #2;
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (done_cnt == 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("done_seen", 64'(done_cnt != 0), 64'd1);
      repeat (3) @(negedge clk);
   endtask

   task automatic check_job(input int cnt);
      chk("accepts", 64'(acc_cnt), 64'(cnt * SEQ_CNT));
      chk("writes", 64'(wr_cnt), 64'(cnt));
      chk("done_once", 64'(done_cnt), 64'd1);
      chk("s2p_clr_once", 64'(s2p_cnt), 64'd1);
      chk("addr_q_empty", 64'(exp_addr_q.size()), 64'd0);
      chk("bram_q_empty", 64'(exp_bram_q.size()), 64'd0);
      chk("busy_end", 64'(busy), 64'd0);
   endtask

   initial begin
      int n;
      rst_n = 1'b0; start = 1'b0; base_addr = '0; word_cnt = '0;
      #3;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_app_en", 64'(app_en), 64'd0);
      chk("rst_app_addr", 64'(app_addr), 64'd0);
      chk("rst_bram_addr", 64'(bram_addr), 64'd0);
      chk("rst_s2p_clr", 64'(s2p_clr), 64'd0);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;

      // Stray read data while idle
      junk_valid = 1;
      repeat (3) @(negedge clk);
      #2 junk_valid = 0;
      repeat (2) @(negedge clk);

      // Basic job, latency 4
      lat = 4;
      start_job(29'h100, 11'd2, 1);
      wait_done(500);
      check_job(2);
      chk("done_after_write", 64'(done_cyc - last_we_cyc), 64'd1);

      // Random app_rdy stalls
      rdy_rand = 1;
      start_job(29'h1000, 11'd3, 1);
      wait_done(1000);
      check_job(3);
      rdy_rand = 0;

      // Long latency: outstanding cap reached
      lat = 40;
      start_job(29'h2000, 11'd8, 1);
      wait_done(2000);
      check_job(8);
      chk("max_outst", 64'(max_outst), 64'(MAX_OUT));

      // Zero-word job
      lat = 4;
      start_job(29'h3000, 11'd0, 1);
      n = 0;
      while (done_cnt == 0 && n < 10) begin
         @(negedge clk);
         #2;
         n++;
      end
      chk("zero_done_lat", 64'(n <= 2 && done_cnt == 1), 64'd1);
      repeat (3) @(negedge clk);
      check_job(0);

      // Start during DRAIN is ignored
      lat = 10;
      start_job(29'h4000, 11'd2, 1);
      n = 0;
      while (acc_cnt < 10 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("drain_reached", 64'(acc_cnt), 64'd10);
      start_job(29'h5000, 11'd1, 0);
      wait_done(500);
      repeat (20) @(negedge clk);
      check_job(2);

      // Reset in the middle of ISSUE
      lat = 6;
      start_job(29'h6000, 11'd4, 1);
      n = 0;
      while (acc_cnt < 5 && n < 200) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("mid_rst_app_en", 64'(app_en), 64'd0);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      chk("mid_rst_app_addr", 64'(app_addr), 64'd0);
      chk("mid_rst_bram_addr", 64'(bram_addr), 64'd0);
      chk("mid_rst_done", 64'(done), 64'd0);
      exp_addr_q.delete();
      exp_bram_q.delete();
      repeat (3) @(negedge clk);
      start_job(29'h200, 11'd2, 1);
      wait_done(500);
      check_job(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
